// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - controller-side start/busy/done handshake and sample bus of the mux scanner
interface mux_scan_sequencer_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         ch_mask;
  logic               busy;
  logic               done;
  logic [3:0]         sample;
  logic [3:0]         sample_valid;

  modport master (
    output start, dwell, ch_mask,
    input  busy, done, sample, sample_valid
  );

  modport slave (
    input  start, dwell, ch_mask,
    output busy, done, sample, sample_valid
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - 4:1 mux channel scanner with dwell timing and per-channel capture
// Optional continuous re-sweep while start stays high: MUX_SCAN_CONTINUOUS_EN
module mux_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 y,
  output logic                 s0,
  output logic                 s1,
  mux_scan_sequencer_if.slave  ctrl
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         ch;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell_eff_q;
  logic [DWELL_W-1:0] cnt;
  logic               wrap_q;
  logic [3:0]         sample_q;
  logic [3:0]         valid_q;

  logic [DWELL_W-1:0] dwell_in_eff;
  logic [2:0]         first_new;
  logic [2:0]         next_ch;

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [2:0] first_set(input logic [3:0] m, input int from);
    first_set = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= from && m[i]) first_set = {1'b1, 2'(i)};
    end
  endfunction

  assign dwell_in_eff = (ctrl.dwell == '0) ? DWELL_W'(1) : ctrl.dwell;
  assign first_new    = first_set(ctrl.ch_mask, 0);
  assign next_ch      = first_set(mask, int'(ch) + 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ctrl.start) state_next = first_new[2] ? SCAN : DONE;
      end
      SCAN: begin
        if (cnt == '0 && !next_ch[2]) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          state_next = (ctrl.start && first_new[2]) ? SCAN : DONE;
`else
          state_next = DONE;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch          <= 2'b00;
      mask        <= 4'b0000;
      dwell_eff_q <= '0;
      cnt         <= '0;
      wrap_q      <= 1'b0;
      sample_q    <= 4'b0000;
      valid_q     <= 4'b0000;
    end else begin
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.start) begin
            mask        <= ctrl.ch_mask;
            dwell_eff_q <= dwell_in_eff;
            valid_q     <= 4'b0000;
            if (first_new[2]) begin
              ch  <= first_new[1:0];
              cnt <= dwell_in_eff - DWELL_W'(1);
            end
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            sample_q[ch] <= y;
            valid_q[ch]  <= 1'b1;
            if (next_ch[2]) begin
              ch  <= next_ch[1:0];
              cnt <= dwell_eff_q - DWELL_W'(1);
            end
`ifdef MUX_SCAN_CONTINUOUS_EN
            // Wrap: relatch controls and restart without a DONE gap cycle
            else if (ctrl.start && first_new[2]) begin
              mask        <= ctrl.ch_mask;
              dwell_eff_q <= dwell_in_eff;
              ch          <= first_new[1:0];
              cnt         <= dwell_in_eff - DWELL_W'(1);
              valid_q     <= 4'b0000;
              wrap_q      <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl.busy         = (state == SCAN);
    ctrl.done         = (state == DONE) || wrap_q;
    ctrl.sample       = sample_q;
    ctrl.sample_valid = valid_q;
    s0                = ch[0];
    s1                = ch[1];
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed-vector bench for mux_scan_sequencer with a behavioural 4:1 mux
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0, s1, y;
  logic [3:0] mux_in;
  int         vectors = 0;
  int         miscompares = 0;

  mux_scan_sequencer_if #(.DWELL_W(4)) bus ();

  mux_scan_sequencer #(.DWELL_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .y    (y),
    .s0   (s0),
    .s1   (s1),
    .ctrl (bus)
  );

  assign y = mux_in[{s1, s0}];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.dwell = 4'd0; bus.ch_mask = 4'h0;
    mux_in = 4'h0;
    repeat (3) step();
    vectors++;
    if ({s1, s0, bus.busy, bus.done, bus.sample, bus.sample_valid} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 000", {s1, s0, bus.busy, bus.done, bus.sample, bus.sample_valid});
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        miscompares++;
        $display("FAIL idle_cycle%0d busy/done got %b want 00", c, {bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_full_sweep();
    logic [1:0] exp_sel[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    mux_in = 4'b1101;
    bus.ch_mask = 4'hF; bus.dwell = 4'd2; bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.busy, bus.done, s1, s0} !== {2'b10, exp_sel[c-1]}) begin
        miscompares++;
        $display("FAIL full_cycle%0d busy/done/sel got %b want %b", c, {bus.busy, bus.done, s1, s0}, {2'b10, exp_sel[c-1]});
      end
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.sample, bus.sample_valid} !== {2'b01, 4'b1101, 4'hF}) begin
      miscompares++;
      $display("FAIL full_done busy/done/sample/valid got %b want %b", {bus.busy, bus.done, bus.sample, bus.sample_valid}, {2'b01, 4'b1101, 4'hF});
    end
    step();
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL full_after_done busy/done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_sparse_zero_dwell();
    mux_in = 4'b0010;
    bus.ch_mask = 4'b1010; bus.dwell = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, s1, s0} !== 4'b1001) begin
      miscompares++;
      $display("FAIL sparse_cycle1 got %b want 1001", {bus.busy, bus.done, s1, s0});
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, s1, s0} !== 4'b1011) begin
      miscompares++;
      $display("FAIL sparse_cycle2 got %b want 1011", {bus.busy, bus.done, s1, s0});
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.sample, bus.sample_valid} !== {2'b01, 4'b0111, 4'b1010}) begin
      miscompares++;
      $display("FAIL sparse_done got %b want %b", {bus.busy, bus.done, bus.sample, bus.sample_valid}, {2'b01, 4'b0111, 4'b1010});
    end
    step();
  endtask

  task automatic test_empty_mask();
    bus.ch_mask = 4'b0000; bus.dwell = 4'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, bus.sample_valid, bus.sample} !== {2'b01, 4'b0000, 4'b0111}) begin
      miscompares++;
      $display("FAIL empty_done got %b want %b", {bus.busy, bus.done, bus.sample_valid, bus.sample}, {2'b01, 4'b0000, 4'b0111});
    end
    step();
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_after busy/done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid_sweep();
    mux_in = 4'hF;
    bus.ch_mask = 4'hF; bus.dwell = 4'd5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    vectors++;
    if ({bus.busy, s1, s0} !== 3'b101) begin
      miscompares++;
      $display("FAIL midrst_cycle7 busy/sel got %b want 101", {bus.busy, s1, s0});
    end
    rst = 1'b1;
    mux_in = 4'b0100;
    bus.ch_mask = 4'b0100; bus.dwell = 4'd1; bus.start = 1'b1;
    step();
    vectors++;
    if ({s1, s0, bus.busy, bus.done, bus.sample, bus.sample_valid} !== 12'h000) begin
      miscompares++;
      $display("FAIL midrst_outputs got %h want 000", {s1, s0, bus.busy, bus.done, bus.sample, bus.sample_valid});
    end
    rst = 1'b0;
    step();
    bus.start = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, s1, s0} !== 4'b1010) begin
      miscompares++;
      $display("FAIL midrst_restart got %b want 1010", {bus.busy, bus.done, s1, s0});
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.sample, bus.sample_valid} !== {2'b01, 4'b0100, 4'b0100}) begin
      miscompares++;
      $display("FAIL midrst_done got %b want %b", {bus.busy, bus.done, bus.sample, bus.sample_valid}, {2'b01, 4'b0100, 4'b0100});
    end
    step();
  endtask

  task automatic test_input_changes();
    mux_in = 4'b0110;
    bus.ch_mask = 4'hF; bus.dwell = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.start = 1'b0; bus.ch_mask = 4'b0001; bus.dwell = 4'd3;
      vectors++;
      if ({bus.busy, bus.done, s1, s0} !== {2'b10, 2'(c - 1)}) begin
        miscompares++;
        $display("FAIL chg_cycle%0d got %b want %b", c, {bus.busy, bus.done, s1, s0}, {2'b10, 2'(c - 1)});
      end
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.sample, bus.sample_valid} !== {2'b01, 4'b0110, 4'hF}) begin
      miscompares++;
      $display("FAIL chg_done got %b want %b", {bus.busy, bus.done, bus.sample, bus.sample_valid}, {2'b01, 4'b0110, 4'hF});
    end
    step();
  endtask

`ifdef MUX_SCAN_CONTINUOUS_EN
  task automatic test_back_to_back();
    logic [3:0] exp_bds[14] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                4'b1100, 4'b1001, 4'b1010, 4'b1011,
                                4'b1100, 4'b1001, 4'b1010, 4'b1011,
                                4'b0111, 4'b0011};
    mux_in = 4'b1001;
    bus.ch_mask = 4'hF; bus.dwell = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 10) bus.start = 1'b0;
      vectors++;
      if ({bus.busy, bus.done, s1, s0} !== exp_bds[c-1]) begin
        miscompares++;
        $display("FAIL cont_cycle%0d got %b want %b", c, {bus.busy, bus.done, s1, s0}, exp_bds[c-1]);
      end
      if (c == 5) begin
        vectors++;
        if (bus.sample_valid !== 4'b0000) begin
          miscompares++;
          $display("FAIL cont_wrap_valid got %b want 0000", bus.sample_valid);
        end
      end
    end
    vectors++;
    if ({bus.sample, bus.sample_valid} !== {4'b1001, 4'hF}) begin
      miscompares++;
      $display("FAIL cont_final sample/valid got %b want %b", {bus.sample, bus.sample_valid}, {4'b1001, 4'hF});
    end
  endtask
`else
  task automatic test_back_to_back();
    logic [3:0] exp_bd[5] = '{4'b1000, 4'b0100, 4'b0000, 4'b1000, 4'b0100};
    mux_in = 4'b0001;
    bus.ch_mask = 4'b0001; bus.dwell = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 4) bus.start = 1'b0;
      vectors++;
      if ({bus.busy, bus.done, s1, s0} !== exp_bd[c-1]) begin
        miscompares++;
        $display("FAIL single_cycle%0d got %b want %b", c, {bus.busy, bus.done, s1, s0}, exp_bd[c-1]);
      end
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse_zero_dwell();
    test_empty_mask();
    test_reset_mid_sweep();
    test_input_changes();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequential channel scanner that drives the `{s1, s0}` select lines of the 4:1 mux and captures the mux output `y` for each enabled channel. It sits directly upstream of the mux on the select path and downstream of it on the data path. It steps through a programmable channel mask, holds each select for a programmable dwell time, and samples `y` at the end of each dwell. A start/busy/done handshake lets a controller request one sweep and collect the four sampled bits.

## Interface

Parameters:
- `DWELL_W`, default 4: width of the dwell-count input.

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  sweep request; sampled only in IDLE.
- `dwell`  input  DWELL_W  cycles each select is held; the value 0 is treated as 1.
- `ch_mask`  input  4  channel-enable mask; bit n enables channel n.
- `y`  input  1  mux output, fed back for sampling.
- `s0`  output  1  select LSB to the mux.
- `s1`  output  1  select MSB to the mux.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse at the end of a sweep.
- `sample`  output  4  captured `y` per channel; bit n holds the value for channel n.
- `sample_valid`  output  4  bit n is set once channel n has been captured in the current sweep.

## Operation

- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - `busy` is 0.
  - On `start`=1, the block latches `dwell` (as `dwell_eff = max(dwell,1)`) and `ch_mask`, and clears `sample_valid`.
  - If the latched mask is nonzero: select the lowest enabled channel, load `cnt = dwell_eff-1`, and go to SCAN.
  - If the latched mask is zero: go straight to DONE, with no channel selected and `sample_valid` staying 0.
- **SCAN**
  - `busy` is 1 and `{s1,s0}` equals the current channel index.
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`==0, the block captures `y` into `sample[ch]` and sets `sample_valid[ch]`.
  - In that same cycle it moves to the next higher enabled channel, reloads `cnt`, and updates the select.
  - If no higher enabled channel exists, it goes to DONE.
- **DONE**
  - `done`=1 and `busy`=0 for one cycle, then the FSM returns to IDLE.
  - `{s1,s0}` hold the last channel.
- Changes to `dwell`, `ch_mask` and `start` during SCAN are ignored; the latched copies are used for the whole sweep.
- `sample` bits of channels disabled in the current sweep keep their previous values.
- Reset mid-sweep:
  - Reset aborts immediately and all outputs take their reset values.
  - No `done` pulse is produced.
  - A `start` held high through reset is acted on in the first cycle after `rst` deasserts.

## Timing

- Reset values: `s0`=0, `s1`=0, `busy`=0, `done`=0, `sample`=4'b0000, `sample_valid`=4'b0000.
- All outputs are registered; there is no combinational path from input to output.
- `start` is sampled at edge k:
  - `busy` is 1 and the select is valid from edge k.
  - Each enabled channel occupies exactly `dwell_eff` cycles of select.
- `y` is sampled on the last cycle of each dwell. The mux path from `{s1,s0}` to `y` must therefore settle within `dwell_eff` cycles; with `dwell_eff`=1 this is one cycle.
- Sweep latency from `start` to `done`: N×`dwell_eff` + 1 cycles, where N is the popcount of the mask. With a zero mask, `done` follows `start` by 1 cycle.
- The minimum gap between sweeps is one IDLE cycle after DONE.

## Configuration

- Macro: `MUX_SCAN_CONTINUOUS_EN`.
- **Defined:**
  - After the last enabled channel, if `start` is still 1, the block wraps to the lowest enabled channel of a freshly latched `ch_mask`/`dwell`.
  - Each wrap pulses `done` for one cycle while `busy` stays 1, clears `sample_valid`, and inserts no DONE gap cycle.
  - If `start`=0 at the wrap point, the FSM goes to DONE, then IDLE.
  - A zero mask at the wrap point also goes to DONE.
- **Undefined:** single-shot only. Every sweep ends in DONE and then IDLE, and `start` held high begins a new sweep in IDLE.

## Test plan

- Reset then idle: `rst`=1 for 3 cycles → all outputs zero; `start`=0 for 10 cycles → `busy`=0 and `done`=0 throughout.
- Full sweep: `ch_mask`=4'hF, `dwell`=2, mux inputs i0..i3 = 1,0,1,1 → select sequence 00,00,01,01,10,10,11,11; `done` pulses at cycle 9 after `start`; `sample`=4'b1101; `sample_valid`=4'hF.
- Sparse mask and zero dwell: `ch_mask`=4'b1010, `dwell`=0 → select 01, then 11, one cycle each; `done` at cycle 3; `sample_valid`=4'b1010; `sample[0]` and `sample[2]` unchanged from the prior sweep.
- Empty mask: `ch_mask`=0, `start` pulse → `done` one cycle later; `busy` never asserts; `sample_valid`=0.
- Reset mid-sweep: `ch_mask`=4'hF, `dwell`=5, assert `rst` at cycle 7 → next cycle `busy`=0, `done`=0, `sample`=0, `sample_valid`=0; a fresh sweep then completes normally.
- Mid-sweep input changes, plus `MUX_SCAN_CONTINUOUS_EN` defined: change `ch_mask`/`dwell` during SCAN → current sweep unaffected; hold `start`=1 → `done` pulses every 4×`dwell_eff` cycles with `busy` continuously 1; drop `start` → one final `done`, then IDLE.
